// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes the pipe on outstanding data-memory
// accesses, bubbles the front end after a taken redirect, and stalls one
// cycle on a load-use dependency. Priority: reset > mem hazard > redirect > load-use.
// Optional performance counters are built when HAZARD_PERF_EN is defined;
// otherwise stall_cnt and flush_cnt are tied to zero.
module hazard_ctrl #(
    parameter int unsigned IW        = 32,
    parameter int unsigned RFW       = 5,
    parameter logic [7:0]  TIMEOUT   = 8'd255,
    parameter int unsigned FLUSH_LEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] idinst,
    input  logic [IW-1:0] exeinst,
    input  logic [IW-1:0] meminst,
    input  logic          br_taken,
    input  logic          mem_ready,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          idex_en,
    output logic          exmem_en,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          memwb_flush,
    output logic          mem_err,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
);

    localparam int unsigned OPW = 5;
    localparam int unsigned WCW = 8;
    localparam int unsigned FCW = 2;

    localparam logic [OPW-1:0] OPC_LOAD   = 5'b00000;
    localparam logic [OPW-1:0] OPC_STORE  = 5'b01000;
    localparam logic [OPW-1:0] OPC_OP     = 5'b01100;
    localparam logic [OPW-1:0] OPC_BRANCH = 5'b11000;
    localparam logic [OPW-1:0] OPC_JAL    = 5'b11011;

    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_FLUSH
    } state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic [FCW-1:0] flush_left, flush_left_nxt;
    logic           flush_pend, flush_pend_nxt;

    logic           redirect_c;
    logic           freeze_c;
    logic           do_run_c;
    logic           do_flush_c;
    logic           mem_hazard_c;
    logic           load_use_c;
    logic           unused_inst;

    // Instruction field decode
    logic [OPW-1:0] id_opc, exe_opc, mem_opc;
    logic [RFW-1:0] rd_exe, rs1_id, rs2_id;

    assign id_opc  = idinst[6:2];
    assign exe_opc = exeinst[6:2];
    assign mem_opc = meminst[6:2];
    assign rd_exe  = exeinst[7 +: RFW];
    assign rs1_id  = idinst[15 +: RFW];
    assign rs2_id  = idinst[20 +: RFW];

    // Only a subset of instruction bits matters here
    assign unused_inst = ^{idinst, exeinst, meminst};

    // Memory access in MEM that has not completed this cycle
    assign mem_hazard_c = ((mem_opc == OPC_LOAD) || (mem_opc == OPC_STORE)) && !mem_ready;

    // Load in EXE whose destination feeds a real source operand of the ID instruction
    assign load_use_c = (exe_opc == OPC_LOAD) && (rd_exe != '0) &&
                        (((rd_exe == rs1_id) && (id_opc != OPC_JAL)) ||
                         ((rd_exe == rs2_id) && ((id_opc == OPC_OP) ||
                                                 (id_opc == OPC_BRANCH) ||
                                                 (id_opc == OPC_STORE))));

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            wait_cnt   <= '0;
            flush_left <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            flush_left <= flush_left_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        flush_left_nxt = flush_left;
        flush_pend_nxt = flush_pend;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        memwb_flush    = 1'b0;
        mem_err        = 1'b0;
        redirect_c     = 1'b0;
        freeze_c       = 1'b0;
        do_run_c       = 1'b0;
        do_flush_c     = 1'b0;

        unique case (state)
            ST_RUN:   do_run_c = 1'b1;
            ST_FLUSH: do_flush_c = 1'b1;
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    // Release cycle behaves as whichever mode the wait interrupted
                    do_run_c   = ~flush_pend;
                    do_flush_c = flush_pend;
                end else if (wait_cnt == TIMEOUT) begin
                    mem_err        = 1'b1;
                    memwb_flush    = 1'b1;
                    flush_pend_nxt = 1'b0;
                    state_nxt      = flush_pend ? ST_FLUSH : ST_RUN;
                end else begin
                    freeze_c     = 1'b1;
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        if (do_run_c) begin
            flush_pend_nxt = 1'b0;
            if (mem_hazard_c) begin
                freeze_c     = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = ST_MEM_WAIT;
            end else if (br_taken) begin
                ifid_flush     = 1'b1;
                idex_flush     = 1'b1;
                redirect_c     = 1'b1;
                flush_left_nxt = FLUSH_INIT;
                state_nxt      = ST_FLUSH;
            end else begin
                state_nxt = ST_RUN;
                if (load_use_c) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end

        if (do_flush_c) begin
            if (mem_hazard_c) begin
                // Remaining flush count is held until the wait resolves
                freeze_c       = 1'b1;
                wait_cnt_nxt   = '0;
                flush_pend_nxt = 1'b1;
                state_nxt      = ST_MEM_WAIT;
            end else begin
                ifid_flush     = 1'b1;
                flush_pend_nxt = 1'b0;
                if (flush_left == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    flush_left_nxt = flush_left - FCW'(1);
                    state_nxt      = ST_FLUSH;
                end
            end
        end

        if (freeze_c) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end

        if (rst) begin
            state_nxt      = ST_RUN;
            wait_cnt_nxt   = '0;
            flush_left_nxt = '0;
            flush_pend_nxt = 1'b0;
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            idex_en        = 1'b0;
            exmem_en       = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            memwb_flush    = 1'b1;
            mem_err        = 1'b0;
            redirect_c     = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Stall and redirect event counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_q <= stall_q + 32'd1;
            end
            if (redirect_c) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (TIMEOUT=4, FLUSH_LEN=2).
module tb_hazard_ctrl;

    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] idinst, exeinst, meminst;
    logic          br_taken, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en;
    logic          ifid_flush, idex_flush, memwb_flush, mem_err;
    logic [31:0]   stall_cnt, flush_cnt;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   exp_stall = '0;
    logic [31:0]   exp_flush = '0;

    string         tag_q[$];
    logic [7:0]    exp_q[$];

    // {pc, ifid, idex, exmem, ifid_flush, idex_flush, memwb_flush, mem_err}
    localparam logic [7:0] RUNV  = 8'b1111_0000;
    localparam logic [7:0] RSTV  = 8'b0000_1110;
    localparam logic [7:0] FRZ   = 8'b0000_0010;
    localparam logic [7:0] REDIR = 8'b1111_1100;
    localparam logic [7:0] FLV   = 8'b1111_1000;
    localparam logic [7:0] LU    = 8'b0011_0100;
    localparam logic [7:0] ERR   = 8'b1111_0011;

    localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_OP = 7'b0110011;
    localparam logic [6:0] O_OPI = 7'b0010011, O_BR = 7'b1100011, O_JAL = 7'b1101111;

    hazard_ctrl #(
        .IW(IW), .RFW(5), .TIMEOUT(8'd4), .FLUSH_LEN(2)
    ) dut (
        .clk(clk), .rst(rst),
        .idinst(idinst), .exeinst(exeinst), .meminst(meminst),
        .br_taken(br_taken), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, rd, opc};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; expected control vector goes through the scoreboard
    task automatic step(input string tag, input logic r, input logic [31:0] id,
                        input logic [31:0] ex, input logic [31:0] mm,
                        input logic br, input logic rdy, input logic [7:0] exp);
        logic [7:0] got;
        @(negedge clk);
        rst = r; idinst = id; exeinst = ex; meminst = mm; br_taken = br; mem_ready = rdy;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        #1;
        got = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, mem_err};
        check(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
        if (!r) begin
            check({tag, "_stall_cnt"}, stall_cnt, exp_stall);
            check({tag, "_flush_cnt"}, flush_cnt, exp_flush);
        end
`ifdef HAZARD_PERF_EN
        if (r) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (!exp[7]) exp_stall = exp_stall + 32'd1;
            if (exp[3] && exp[2]) exp_flush = exp_flush + 32'd1;
        end
`endif
    endtask

    initial begin
        logic [31:0] nop, lw5, lw0, add_rs1, add_rs2, add_x0, addi_rs1, addi_f5;
        logic [31:0] jal_f5, sw_rs2, beq_rs2, op5, sw_m;
        nop      = mk(O_OPI, 5'd0, 5'd0, 5'd0);
        lw5      = mk(O_LOAD, 5'd5, 5'd1, 5'd0);
        lw0      = mk(O_LOAD, 5'd0, 5'd1, 5'd0);
        add_rs1  = mk(O_OP, 5'd6, 5'd5, 5'd7);
        add_rs2  = mk(O_OP, 5'd6, 5'd7, 5'd5);
        add_x0   = mk(O_OP, 5'd6, 5'd0, 5'd0);
        addi_rs1 = mk(O_OPI, 5'd6, 5'd5, 5'd0);
        addi_f5  = mk(O_OPI, 5'd6, 5'd3, 5'd5);
        jal_f5   = mk(O_JAL, 5'd1, 5'd5, 5'd0);
        sw_rs2   = mk(O_STORE, 5'd0, 5'd3, 5'd5);
        beq_rs2  = mk(O_BR, 5'd0, 5'd3, 5'd5);
        op5      = mk(O_OP, 5'd5, 5'd1, 5'd2);
        sw_m     = mk(O_STORE, 5'd0, 5'd2, 5'd3);

        rst = 1'b1; idinst = nop; exeinst = nop; meminst = nop; br_taken = 1'b0; mem_ready = 1'b1;

        // Reset state
        step("rst0", 1, nop, nop, nop, 0, 1, RSTV);
        step("rst1", 1, add_rs1, lw5, sw_m, 1, 0, RSTV);
        step("idle", 0, nop, nop, nop, 0, 1, RUNV);

        // Load-use detection
        step("lu_rs1",   0, add_rs1, lw5, nop, 0, 1, LU);
        step("lu_after", 0, add_rs1, nop, nop, 0, 1, RUNV);
        step("lu_rs2",   0, add_rs2, lw5, nop, 0, 1, LU);
        step("lu_x0",    0, add_x0, lw0, nop, 0, 1, RUNV);
        step("lu_addi",  0, addi_rs1, lw5, nop, 0, 1, LU);
        step("lu_immf",  0, addi_f5, lw5, nop, 0, 1, RUNV);
        step("lu_jal",   0, jal_f5, lw5, nop, 0, 1, RUNV);
        step("lu_sw",    0, sw_rs2, lw5, nop, 0, 1, LU);
        step("lu_beq",   0, beq_rs2, lw5, nop, 0, 1, LU);
        step("lu_noload",0, add_rs1, op5, nop, 0, 1, RUNV);

        // Store waits three cycles, completes on the fourth
        step("mw_c0",  0, nop, nop, sw_m, 0, 0, FRZ);
        step("mw_c1",  0, nop, nop, sw_m, 0, 0, FRZ);
        step("mw_c2",  0, nop, nop, sw_m, 0, 0, FRZ);
        step("mw_rel", 0, nop, nop, sw_m, 0, 1, RUNV);
        step("mw_post",0, nop, nop, nop, 0, 0, RUNV);

        // Redirect with br_taken held through the flush window
        step("br_c0", 0, nop, nop, nop, 1, 1, REDIR);
        step("br_c1", 0, nop, nop, nop, 1, 1, FLV);
        step("br_c2", 0, nop, nop, nop, 1, 1, FLV);
        step("br_c3", 0, nop, nop, nop, 0, 1, RUNV);

        // Mem hazard beats redirect and load-use; redirect acted on at release
        step("pri_frz", 0, add_rs1, lw5, lw5, 1, 0, FRZ);
        step("pri_rel", 0, add_rs1, lw5, lw5, 1, 1, REDIR);
        step("pri_f1",  0, nop, nop, nop, 0, 1, FLV);
        step("pri_f2",  0, nop, nop, nop, 0, 1, FLV);
        step("pri_run", 0, nop, nop, nop, 0, 1, RUNV);

        // Redirect beats load-use
        step("bl_c0",  0, add_rs1, lw5, nop, 1, 1, REDIR);
        step("bl_c1",  0, nop, nop, nop, 0, 1, FLV);
        step("bl_c2",  0, nop, nop, nop, 0, 1, FLV);
        step("bl_run", 0, nop, nop, nop, 0, 1, RUNV);

        // Mem hazard inside FLUSH; flush resumes after the wait
        step("fm_c0",  0, nop, nop, nop, 1, 1, REDIR);
        step("fm_frz", 0, nop, nop, lw5, 0, 0, FRZ);
        step("fm_mw",  0, nop, nop, lw5, 0, 0, FRZ);
        step("fm_rel", 0, nop, nop, lw5, 0, 1, FLV);
        step("fm_f2",  0, nop, nop, nop, 0, 1, FLV);
        step("fm_run", 0, nop, nop, nop, 0, 1, RUNV);

        // Timeout: four frozen MEM_WAIT cycles, then a single error pulse
        step("to_run", 0, nop, nop, lw5, 0, 0, FRZ);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("to_w%0d", i), 0, nop, nop, lw5, 0, 0, FRZ);
        end
        step("to_err",  0, nop, nop, lw5, 0, 0, ERR);
        step("to_post", 0, nop, nop, nop, 0, 0, RUNV);

        // Reset during FLUSH cycle 1
        step("rf_c0",  0, nop, nop, nop, 1, 1, REDIR);
        step("rf_rst", 1, nop, nop, nop, 0, 1, RSTV);
        step("rf_r0",  0, nop, nop, nop, 0, 1, RUNV);
        step("rf_r1",  0, nop, nop, nop, 0, 1, RUNV);

        // Reset during MEM_WAIT
        step("rm_frz", 0, nop, nop, lw5, 0, 0, FRZ);
        step("rm_mw",  0, nop, nop, lw5, 0, 0, FRZ);
        step("rm_rst", 1, nop, nop, lw5, 0, 0, RSTV);
        step("rm_r0",  0, nop, nop, nop, 0, 0, RUNV);
        step("rm_end", 0, nop, nop, nop, 0, 1, RUNV);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
